// File: rtl/exu_bjp_resolve.sv
// Branch/jump resolve unit: queues committed branches, checks actual outcomes in order,
// and raises a registered redirect on a mispredict.
module exu_bjp_resolve #(
  parameter int PC_SIZE = 32,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmt_i_valid,
  output logic                         cmt_i_ready,
  input  logic                         cmt_i_bjp,
  input  logic                         cmt_i_bjp_prdt,
  input  logic [PC_SIZE-1:0]           cmt_i_pc,
  input  logic [XLEN-1:0]              cmt_i_imm,
  input  logic                         rslv_i_valid,
  output logic                         rslv_i_ready,
  input  logic                         rslv_i_taken,
  output logic                         flush_o_valid,
  input  logic                         flush_o_ready,
  output logic [PC_SIZE-1:0]           flush_o_pc,
  output logic [$clog2(DEPTH):0]       pend_o_cnt,
  output logic [15:0]                  mispr_o_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PC_SIZE-1:0]   q_pc_q   [DEPTH];
  logic [PC_SIZE-1:0]   q_pc_d   [DEPTH];
  logic [PC_SIZE-1:0]   q_imm_q  [DEPTH];
  logic [PC_SIZE-1:0]   q_imm_d  [DEPTH];
  logic [DEPTH-1:0]     q_prdt_q, q_prdt_d;
  logic [PC_SIZE-1:0]   flush_pc_q, flush_pc_d;
  logic [15:0]          mispr_cnt_q, mispr_cnt_d;

  logic                 push, pop, mispr;
  logic [PTR_W-1:0]     wr_idx, rd_idx;
  logic [PC_SIZE-1:0]   head_pc, head_imm, head_target, head_fall;

  // Only the low PC_SIZE bits of the offset matter: target arithmetic wraps at PC width.
  generate
    if (XLEN > PC_SIZE) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^cmt_i_imm[XLEN-1:PC_SIZE];
    end
  endgenerate

  assign pend_o_cnt   = wr_ptr_q - rd_ptr_q;
  assign cmt_i_ready  = (state_q == IDLE) && (pend_o_cnt < CNT_W'(DEPTH));
  assign rslv_i_ready = (state_q == IDLE) && (pend_o_cnt != '0);
  assign flush_o_valid = (state_q == FLUSH);
  assign flush_o_pc    = flush_pc_q;
  assign mispr_o_cnt   = mispr_cnt_q;

  assign wr_idx      = wr_ptr_q[PTR_W-1:0];
  assign rd_idx      = rd_ptr_q[PTR_W-1:0];
  assign head_pc     = q_pc_q[rd_idx];
  assign head_imm    = q_imm_q[rd_idx];
  assign head_target = head_pc + head_imm;
  assign head_fall   = head_pc + PC_SIZE'(4);

  assign push  = cmt_i_valid && cmt_i_ready && cmt_i_bjp;
  assign pop   = rslv_i_valid && rslv_i_ready;
  assign mispr = pop && (rslv_i_taken != q_prdt_q[rd_idx]);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    q_pc_d      = q_pc_q;
    q_imm_d     = q_imm_q;
    q_prdt_d    = q_prdt_q;
    flush_pc_d  = flush_pc_q;
    mispr_cnt_d = mispr_cnt_q;

    if (push) begin
      q_pc_d[wr_idx]   = cmt_i_pc;
      q_imm_d[wr_idx]  = cmt_i_imm[PC_SIZE-1:0];
      q_prdt_d[wr_idx] = cmt_i_bjp_prdt;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // A mispredict kills everything younger, including a same-cycle push.
    if (mispr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      flush_pc_d = rslv_i_taken ? head_target : head_fall;
      state_d    = FLUSH;
      if (mispr_cnt_q != 16'hFFFF) mispr_cnt_d = mispr_cnt_q + 16'd1;
    end

    if (state_q == FLUSH && flush_o_ready) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      q_pc_q      <= '{default: '0};
      q_imm_q     <= '{default: '0};
      q_prdt_q    <= '0;
      flush_pc_q  <= '0;
      mispr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      q_pc_q      <= q_pc_d;
      q_imm_q     <= q_imm_d;
      q_prdt_q    <= q_prdt_d;
      flush_pc_q  <= flush_pc_d;
      mispr_cnt_q <= mispr_cnt_d;
    end
  end

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// Directed bench for exu_bjp_resolve with hand-computed expectations.
module tb_exu_bjp_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmt_i_valid, cmt_i_bjp, cmt_i_bjp_prdt;
  logic        cmt_i_ready;
  logic [31:0] cmt_i_pc, cmt_i_imm;
  logic        rslv_i_valid, rslv_i_taken, rslv_i_ready;
  logic        flush_o_valid, flush_o_ready;
  logic [31:0] flush_o_pc;
  logic [2:0]  pend_o_cnt;
  logic [15:0] mispr_o_cnt;

  int checks = 0;
  int failures = 0;

  exu_bjp_resolve #(.PC_SIZE(32), .XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready), .cmt_i_bjp(cmt_i_bjp),
    .cmt_i_bjp_prdt(cmt_i_bjp_prdt), .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm),
    .rslv_i_valid(rslv_i_valid), .rslv_i_ready(rslv_i_ready), .rslv_i_taken(rslv_i_taken),
    .flush_o_valid(flush_o_valid), .flush_o_ready(flush_o_ready), .flush_o_pc(flush_o_pc),
    .pend_o_cnt(pend_o_cnt), .mispr_o_cnt(mispr_o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmt_i_valid = 0; cmt_i_bjp = 0; cmt_i_bjp_prdt = 0; cmt_i_pc = 0; cmt_i_imm = 0;
    rslv_i_valid = 0; rslv_i_taken = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] imm, input logic prdt);
    cmt_i_valid = 1; cmt_i_bjp = 1; cmt_i_pc = pc; cmt_i_imm = imm; cmt_i_bjp_prdt = prdt;
  endtask

  task automatic resolve(input logic taken);
    rslv_i_valid = 1; rslv_i_taken = taken;
  endtask

  task automatic finish_flush();
    flush_o_ready = 1;
    tick();
    flush_o_ready = 0;
  endtask

  initial begin
    rst = 1; flush_o_ready = 0;
    idle_inputs();
    #12;
    check("rst_flush_valid", 32'(flush_o_valid), 32'd0);
    check("rst_flush_pc", flush_o_pc, 32'd0);
    check("rst_pend", 32'(pend_o_cnt), 32'd0);
    check("rst_mispr", 32'(mispr_o_cnt), 32'd0);
    tick();
    rst = 0;
    #1;
    check("post_rst_cmt_ready", 32'(cmt_i_ready), 32'd1);
    check("post_rst_rslv_ready", 32'(rslv_i_ready), 32'd0);

    // correct prediction: pop only
    push(32'h8000_0000, 32'h10, 1'b1);
    tick(); idle_inputs();
    check("c1_pend_after_push", 32'(pend_o_cnt), 32'd1);
    resolve(1'b1);
    tick(); idle_inputs();
    check("c1_pend_after_pop", 32'(pend_o_cnt), 32'd0);
    check("c1_no_flush", 32'(flush_o_valid), 32'd0);
    check("c1_mispr", 32'(mispr_o_cnt), 32'd0);

    // mispredict not-taken, flush held while fetch stalls
    push(32'h8000_0100, 32'h40, 1'b1);
    tick(); idle_inputs();
    resolve(1'b0);
    tick(); idle_inputs();
    check("c2_flush_valid", 32'(flush_o_valid), 32'd1);
    check("c2_flush_pc", flush_o_pc, 32'h8000_0104);
    check("c2_mispr", 32'(mispr_o_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c2_hold_valid", 32'(flush_o_valid), 32'd1);
      check("c2_hold_pc", flush_o_pc, 32'h8000_0104);
      check("c2_hold_cmt_ready", 32'(cmt_i_ready), 32'd0);
    end
    finish_flush();
    #1;
    check("c2_flush_done", 32'(flush_o_valid), 32'd0);
    check("c2_cmt_ready_back", 32'(cmt_i_ready), 32'd1);

    // fill queue, mispredict oldest (taken), younger entries dropped
    for (int i = 0; i < 4; i++) begin
      push(32'h1000 + 32'(i) * 32'h100, 32'h20, 1'b0);
      tick();
    end
    idle_inputs();
    #1;
    check("c3_full_pend", 32'(pend_o_cnt), 32'd4);
    check("c3_full_cmt_ready", 32'(cmt_i_ready), 32'd0);
    check("c3_full_rslv_ready", 32'(rslv_i_ready), 32'd1);
    resolve(1'b1);
    tick(); idle_inputs();
    check("c3_pend_cleared", 32'(pend_o_cnt), 32'd0);
    check("c3_flush_pc", flush_o_pc, 32'h0000_1020);
    check("c3_mispr", 32'(mispr_o_cnt), 32'd2);
    finish_flush();
    #1;
    check("c3_younger_gone", 32'(rslv_i_ready), 32'd0);

    // wrap-around targets
    push(32'hFFFF_FFFC, 32'h8, 1'b0);
    tick(); idle_inputs();
    resolve(1'b1);
    tick(); idle_inputs();
    check("c4_wrap_target", flush_o_pc, 32'h0000_0004);
    finish_flush();
    push(32'hFFFF_FFFC, 32'h8, 1'b1);
    tick(); idle_inputs();
    resolve(1'b0);
    tick(); idle_inputs();
    check("c4_wrap_fall", flush_o_pc, 32'h0000_0000);
    check("c4_mispr", 32'(mispr_o_cnt), 32'd4);
    finish_flush();

    // non-branch commit and resolve with empty queue
    cmt_i_valid = 1; cmt_i_bjp = 0; cmt_i_pc = 32'h500;
    resolve(1'b1);
    #1;
    check("c5_rslv_ready_empty", 32'(rslv_i_ready), 32'd0);
    tick(); idle_inputs();
    check("c5_pend", 32'(pend_o_cnt), 32'd0);
    check("c5_no_flush", 32'(flush_o_valid), 32'd0);
    check("c5_mispr", 32'(mispr_o_cnt), 32'd4);

    // simultaneous push + correct pop keeps count and order
    push(32'h200, 32'h10, 1'b1);
    tick();
    push(32'h300, 32'h10, 1'b0);
    resolve(1'b1);
    tick(); idle_inputs();
    check("c6_pend_same", 32'(pend_o_cnt), 32'd1);
    check("c6_no_flush", 32'(flush_o_valid), 32'd0);
    resolve(1'b0);
    tick(); idle_inputs();
    check("c6_order_pend", 32'(pend_o_cnt), 32'd0);
    check("c6_order_no_flush", 32'(flush_o_valid), 32'd0);

    // simultaneous push + mispredict drops the pushed entry
    push(32'h400, 32'h10, 1'b1);
    tick();
    push(32'h600, 32'h10, 1'b1);
    resolve(1'b0);
    tick(); idle_inputs();
    check("c7_pend_zero", 32'(pend_o_cnt), 32'd0);
    check("c7_flush_pc", flush_o_pc, 32'h0000_0404);
    check("c7_mispr", 32'(mispr_o_cnt), 32'd5);

    // async reset mid-flush
    #2 rst = 1;
    #1;
    check("c8_rst_flush_valid", 32'(flush_o_valid), 32'd0);
    check("c8_rst_mispr", 32'(mispr_o_cnt), 32'd0);
    check("c8_rst_flush_pc", flush_o_pc, 32'd0);
    tick();
    rst = 0;
    tick();
    check("c8_cmt_ready", 32'(cmt_i_ready), 32'd1);
    check("c8_flush_after", 32'(flush_o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_bjp_resolve.md
EXU_BJP_RESOLVE -- requirements
Module: exu_bjp_resolve

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, the program counter width.
REQ-002 SHALL have parameter XLEN, default 32, the immediate width; XLEN >= PC_SIZE.
REQ-003 SHALL have parameter DEPTH, default 4, the pending-branch queue entries; a power of two, >= 2.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmt_i_valid  input  1  commit request valid.
REQ-007 SHALL have port cmt_i_ready  output  1  commit request accepted.
REQ-008 SHALL have port cmt_i_bjp  input  1  committed instruction is a branch/jump.
REQ-009 SHALL have port cmt_i_bjp_prdt  input  1  predicted taken.
REQ-010 SHALL have port cmt_i_pc  input  PC_SIZE  branch PC.
REQ-011 SHALL have port cmt_i_imm  input  XLEN  branch offset.
REQ-012 SHALL have port rslv_i_valid  input  1  actual outcome of the oldest pending branch is valid.
REQ-013 SHALL have port rslv_i_ready  output  1  outcome accepted.
REQ-014 SHALL have port rslv_i_taken  input  1  actual taken.
REQ-015 SHALL have port flush_o_valid  output  1  redirect request.
REQ-016 SHALL have port flush_o_ready  input  1  redirect accepted by the fetch stage.
REQ-017 SHALL have port flush_o_pc  output  PC_SIZE  redirect PC.
REQ-018 SHALL have port pend_o_cnt  output  log2(DEPTH)+1  number of occupied queue entries.
REQ-019 SHALL have port mispr_o_cnt  output  16  mispredict count.

Function
REQ-020 SHALL implement a two-state FSM, IDLE and FLUSH.
REQ-021 SHALL drive cmt_i_ready = (state==IDLE) && (pend_o_cnt < DEPTH) && !rslv_i_valid-handshake-independent, i.e. it SHALL NOT depend on rslv_i_valid.
REQ-022 SHALL treat a commit handshake as cmt_i_valid && cmt_i_ready; with cmt_i_bjp=1 it pushes {pc, imm, prdt}, and with cmt_i_bjp=0 it is consumed with no state change.
REQ-023 SHALL drive rslv_i_ready = (state==IDLE) && (pend_o_cnt != 0); with the queue empty, a resolve is never accepted.
REQ-024 SHALL treat a resolve handshake as rslv_i_valid && rslv_i_ready; it pops the oldest entry in order.
REQ-025 SHALL compute the target as pc + imm[PC_SIZE-1:0], modulo 2^PC_SIZE, and the fall-through as pc + 4, modulo 2^PC_SIZE; wrap-around is silent.
REQ-026 SHALL handle a resolve with taken == prdt by popping only: no flush, no counter change.
REQ-027 SHALL handle a resolve with taken != prdt, on the same edge, by: popping the entry, discarding all younger entries (pend_o_cnt -> 0), registering flush_o_pc (target if taken, else fall-through), moving to FLUSH, and incrementing mispr_o_cnt, which saturates at 16'hFFFF.
REQ-028 SHALL hold flush_o_valid = 1 exactly while in FLUSH, with flush_o_pc stable until flush_o_ready.
REQ-029 SHALL return to IDLE on flush_o_valid && flush_o_ready; the earliest next commit or resolve is accepted the following cycle.
REQ-030 SHALL make the first flush_o_valid visible one cycle after the mispredicting resolve handshake.
REQ-031 SHALL perform a simultaneous commit push and correct resolve pop in one cycle, leaving the count unchanged and preserving order.
REQ-032 SHALL, on a simultaneous commit push and mispredicting resolve, discard the pushed entry as well (pend_o_cnt = 0).
REQ-033 SHALL keep a full queue non-blocking for resolves; only commits stall.
REQ-034 SHALL derive pend_o_cnt from registered pointers, updated on the handshake edge.

Reset
REQ-035 SHALL, while rst=1 and regardless of clk, force state=IDLE, queue pointers=0, pend_o_cnt=0, mispr_o_cnt=0, flush_o_valid=0 and flush_o_pc=0.
REQ-036 SHALL, when reset is asserted mid-FLUSH, drop the pending redirect without a handshake.
REQ-037 SHALL assert cmt_i_ready in the first cycle after rst deasserts.

Verification
REQ-038 SHALL cover: push pc=0x80000000, imm=0x10, prdt=1; resolve taken=1 -> no flush_o_valid, pend_o_cnt 1->0, mispr_o_cnt=0.
REQ-039 SHALL cover: push pc=0x80000100, prdt=1; resolve taken=0 -> next cycle flush_o_valid=1 with flush_o_pc=0x80000104, mispr_o_cnt=1; flush_o_ready held low 3 cycles -> valid and pc held, cmt_i_ready=0.
REQ-040 SHALL cover: push 4 branches (DEPTH=4) -> cmt_i_ready=0, pend_o_cnt=4; mispredict the oldest -> pend_o_cnt=0, the 3 younger entries are never resolvable.
REQ-041 SHALL cover: pc=0xFFFFFFFC, imm=0x8, prdt=0, taken=1 -> flush_o_pc=0x00000004; pc=0xFFFFFFFC, prdt=1, taken=0 -> flush_o_pc=0x00000000.
REQ-042 SHALL cover: a non-branch commit (bjp=0) and rslv_i_valid with an empty queue -> pend_o_cnt stays 0, rslv_i_ready=0, no flush.
REQ-043 SHALL cover: rst asserted asynchronously mid-FLUSH with mispr_o_cnt=5 -> flush_o_valid=0 and mispr_o_cnt=0 immediately, and cmt_i_ready=1 one cycle after release.
